// File: rtl/common_fifo_reader_pkg.sv
// Shared definitions for the FIFO read-side valid/ready adapter:
// state encodings (which double as the occupancy value) and the occupancy width.
package common_fifo_reader_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      ST_EMPTY = 2'b00,
      ST_HALF  = 2'b01,
      ST_FULL  = 2'b10
   } state_e;

endpackage

// File: rtl/common_fifo_reader_vr.sv
// Pops a first-word-fall-through FIFO head into a 2-entry skid buffer (head + skid)
// and presents it on a registered valid/ready interface; fifo_ren never sees m_ready.
module common_fifo_reader_vr
   import common_fifo_reader_pkg::*;
#(
   parameter int DATA_WIDTH  = 1,
   parameter int COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   input  logic                   fifo_empty,
   output logic                   fifo_ren,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   input  logic                   flush,
   output logic [OCC_W-1:0]       occupancy,
   output logic [COUNT_WIDTH-1:0] beat_count
);

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  head_q, head_d;
   logic [DATA_WIDTH-1:0]  skid_q, skid_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   pop_ok;
   logic                   pop;
   logic                   accept;

   // Only legal non-full states may pop, so an illegal encoding never loses a popped word.
   assign pop_ok     = (state_q == ST_EMPTY) || (state_q == ST_HALF);
   assign fifo_ren   = ~reset & ~flush & ~fifo_empty & pop_ok;
   assign pop        = fifo_ren;
   assign m_valid    = (state_q == ST_HALF) || (state_q == ST_FULL);
   assign accept     = m_valid & m_ready;
   assign m_data     = head_q;
   assign occupancy  = state_q;
   assign beat_count = cnt_q;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      cnt_d   = cnt_q + COUNT_WIDTH'(accept);
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (pop) begin
                  state_d = ST_HALF;
                  head_d  = fifo_dout;
               end
            end
            ST_HALF: begin
               if (pop && accept) begin
                  head_d = fifo_dout;
               end else if (pop) begin
                  state_d = ST_FULL;
                  skid_d  = fifo_dout;
               end else if (accept) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (accept) begin
                  state_d = ST_HALF;
                  head_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_common_fifo_reader_vr.sv
// Directed bench for common_fifo_reader_vr: a small FWFT FIFO model feeds two
// instances (8-bit and 2-bit beat counters) that share all inputs.
module tb_common_fifo_reader_vr;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic       m_ready;
   logic [3:0] fifo_dout;
   logic       fifo_empty;
   logic       fifo_ren;
   logic [3:0] m_data;
   logic       m_valid;
   logic [1:0] occupancy;
   logic [7:0] beat_count;

   logic       fifo_ren2;
   logic [3:0] m_data2;
   logic       m_valid2;
   logic [1:0] occupancy2;
   logic [1:0] beat_count2;

   logic [3:0] mem [0:15];
   logic [3:0] wr_ptr = 4'd0;
   logic [3:0] rd_ptr = 4'd0;

   int tests_run = 0;
   int failures  = 0;
   int exp_cnt   = 0;

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_dout  = mem[rd_ptr];

   always @(posedge clk) begin
      if (fifo_ren) rd_ptr <= rd_ptr + 4'd1;
   end

   common_fifo_reader_vr #(.DATA_WIDTH(4), .COUNT_WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_ren(fifo_ren), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .flush(flush), .occupancy(occupancy), .beat_count(beat_count)
   );

   common_fifo_reader_vr #(.DATA_WIDTH(4), .COUNT_WIDTH(2)) u_dut_w2 (
      .clk(clk), .reset(reset), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_ren(fifo_ren2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
      .flush(flush), .occupancy(occupancy2), .beat_count(beat_count2)
   );

   task automatic push(input logic [3:0] d);
      mem[wr_ptr] = d;
      wr_ptr      = wr_ptr + 4'd1;
   endtask

   task automatic test_reset();
      push(4'h5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold cyc%0d: ren=%b valid=%b occ=%0d, required 0/0/0",
                     i, fifo_ren, m_valid, occupancy);
         end
      end
      tests_run++;
      if (m_data !== 4'h0 || beat_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_values: data=%h cnt=%0d, required 0/0", m_data, beat_count);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if (fifo_ren !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ren: ren=%b, required 1", fifo_ren);
      end
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 4'h5 || occupancy !== 2'd1) begin
         failures++;
         $display("FAIL first_beat: valid=%b data=%h occ=%0d, required 1/5/1",
                  m_valid, m_data, occupancy);
      end
      m_ready = 1'b1;
      exp_cnt = 1;
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b0 || beat_count !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL first_accept: valid=%b cnt=%0d, required 0/%0d", m_valid, beat_count, exp_cnt);
      end
   endtask

   task automatic test_streaming();
      for (int i = 1; i <= 8; i++) push(4'(i));
      @(negedge clk);
      for (int i = 1; i <= 8; i++) begin
         tests_run++;
         if (m_valid !== 1'b1 || m_data !== 4'(i) || occupancy === 2'd2) begin
            failures++;
            $display("FAIL stream_beat%0d: valid=%b data=%h occ=%0d, required 1/%h/not2",
                     i, m_valid, m_data, occupancy, 4'(i));
         end
         @(negedge clk);
      end
      exp_cnt += 8;
      tests_run++;
      if (m_valid !== 1'b0 || beat_count !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL stream_end: valid=%b cnt=%0d, required 0/%0d", m_valid, beat_count, exp_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] exp_seq [0:2];
      exp_seq[0] = 4'hA; exp_seq[1] = 4'hB; exp_seq[2] = 4'hC;
      m_ready = 1'b0;
      push(4'hA); push(4'hB); push(4'hC);
      @(negedge clk);
      tests_run++;
      if (occupancy !== 2'd1 || m_data !== 4'hA || fifo_ren !== 1'b1) begin
         failures++;
         $display("FAIL bp_first_pop: occ=%0d data=%h ren=%b, required 1/a/1", occupancy, m_data, fifo_ren);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests_run++;
         if (occupancy !== 2'd2 || m_data !== 4'hA || m_valid !== 1'b1 || fifo_ren !== 1'b0) begin
            failures++;
            $display("FAIL bp_full%0d: occ=%0d data=%h valid=%b ren=%b, required 2/a/1/0",
                     i, occupancy, m_data, m_valid, fifo_ren);
         end
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if (m_valid !== 1'b1 || m_data !== exp_seq[i]) begin
            failures++;
            $display("FAIL bp_drain%0d: valid=%b data=%h, required 1/%h", i, m_valid, m_data, exp_seq[i]);
         end
         @(negedge clk);
      end
      exp_cnt += 3;
      tests_run++;
      if (m_valid !== 1'b0 || beat_count !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL bp_end: valid=%b cnt=%0d, required 0/%0d", m_valid, beat_count, exp_cnt);
      end
   endtask

   task automatic test_flush();
      m_ready = 1'b0;
      push(4'h3); push(4'h4);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (occupancy !== 2'd2 || m_data !== 4'h3) begin
         failures++;
         $display("FAIL flush_setup: occ=%0d data=%h, required 2/3", occupancy, m_data);
      end
      push(4'h7);
      flush   = 1'b1;
      m_ready = 1'b1;
      #1;
      tests_run++;
      if (fifo_ren !== 1'b0) begin
         failures++;
         $display("FAIL flush_ren: ren=%b, required 0", fifo_ren);
      end
      @(negedge clk);
      flush = 1'b0;
      exp_cnt += 1;
      tests_run++;
      if (occupancy !== 2'd0 || m_valid !== 1'b0 || beat_count !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL flush_result: occ=%0d valid=%b cnt=%0d, required 0/0/%0d",
                  occupancy, m_valid, beat_count, exp_cnt);
      end
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 4'h7) begin
         failures++;
         $display("FAIL flush_next: valid=%b data=%h, required 1/7", m_valid, m_data);
      end
      @(negedge clk);
      exp_cnt += 1;
      tests_run++;
      if (m_valid !== 1'b0 || beat_count !== 8'(exp_cnt)) begin
         failures++;
         $display("FAIL flush_drain: valid=%b cnt=%0d, required 0/%0d", m_valid, beat_count, exp_cnt);
      end
   endtask

   task automatic test_counter_wrap();
      logic [1:0] exp_w [0:4];
      exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;
      reset = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      exp_cnt = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(4'(i + 1));
      @(negedge clk);
      tests_run++;
      if (beat_count2 !== 2'd0) begin
         failures++;
         $display("FAIL wrap_start: cnt=%0d, required 0", beat_count2);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if (beat_count2 !== exp_w[i]) begin
            failures++;
            $display("FAIL wrap_cnt%0d: cnt=%0d, required %0d", i, beat_count2, exp_w[i]);
         end
      end
      tests_run++;
      if (beat_count !== 8'd5) begin
         failures++;
         $display("FAIL wrap_wide_cnt: cnt=%0d, required 5", beat_count);
      end
   endtask

   task automatic test_async_reset();
      m_ready = 1'b0;
      push(4'h9); push(4'hA);
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (occupancy !== 2'd2 || m_valid !== 1'b1) begin
         failures++;
         $display("FAIL areset_setup: occ=%0d valid=%b, required 2/1", occupancy, m_valid);
      end
      push(4'hB);
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (m_valid !== 1'b0 || occupancy !== 2'd0 || fifo_ren !== 1'b0 || beat_count !== 8'd0) begin
         failures++;
         $display("FAIL areset_immediate: valid=%b occ=%0d ren=%b cnt=%0d, required 0/0/0/0",
                  m_valid, occupancy, fifo_ren, beat_count);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 4'hB) begin
         failures++;
         $display("FAIL areset_recover: valid=%b data=%h, required 1/b", m_valid, m_data);
      end
   endtask

   initial begin
      reset   = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_counter_wrap();
      test_async_reset();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
